// File: rtl/sdram_ctrl_pkg.sv
// Shared types for the SDRAM control unit: FSM states, decoded commands,
// transfer size codes and the burst column generator.
package sdram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ACT   = 3'd2,
    LAT   = 3'd3,
    BURST = 3'd4,
    WAIT  = 3'd5
  } ldState_t;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PRE,
    CMD_ACT,
    CMD_WRITE,
    CMD_READ
  } cmd_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Active-low JEDEC-style command lines, {RAS,CAS,WE} with CS low.
  function automatic cmd_t decodeCmd(input logic cs, input logic ras,
                                     input logic cas, input logic we);
    cmd_t cmd;
    cmd = CMD_NOP;
    if (!cs) begin
      case ({ras, cas, we})
        3'b010:  cmd = CMD_PRE;
        3'b011:  cmd = CMD_ACT;
        3'b100:  cmd = CMD_WRITE;
        3'b101:  cmd = CMD_READ;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

  // A programmed duration of N cycles loads N-1; zero is treated as one cycle.
  function automatic logic [7:0] timerLoad(input logic [7:0] n);
    return (n == 8'd0) ? 8'd0 : n - 8'd1;
  endfunction

  // Column for a burst beat: linear wraps at 256, sequential wraps inside a
  // 2^k aligned block while the upper bits stay fixed.
  function automatic logic [7:0] colGen(input logic [7:0] startCol,
                                        input logic [7:0] beat,
                                        input logic [2:0] k,
                                        input logic linear);
    logic [7:0] mask;
    logic [7:0] sum;
    mask = (8'd1 << k) - 8'd1;
    sum  = startCol + beat;
    return linear ? sum : ((startCol & ~mask) | (sum & mask));
  endfunction

endpackage

// File: rtl/sdram_control_unit_if.sv
// Bus-side bundle of the SDRAM control unit.
// Handshake: there is no valid/ready pair. A command is a single-cycle
// CS-low strobe sampled only while the unit is idle; BusySignalOut low is
// the "ready" indication, and anything presented while busy is dropped.
interface sdram_control_unit_if;
  logic        CS, RAS, CAS, WeIn;
  logic [31:0] AddrIn;
  logic [1:0]  SizeIn;
  logic [7:0]  tburst;
  logic [2:0]  tburst_config;
  logic        addr_mode;
  logic [3:0]  tlat;
  logic [7:0]  tpre, tcas, twait;
  logic        WeOut, ReOut, PrechargeOut, ActivateOut, BusySignalOut;
  logic [7:0]  RowAddr, ColAddr;
  logic [1:0]  SizeOut;
  logic [2:0]  LdState;
  logic        RwState;

  modport master (
    output CS, RAS, CAS, WeIn, AddrIn, SizeIn, tburst, tburst_config,
           addr_mode, tlat, tpre, tcas, twait,
    input  WeOut, ReOut, PrechargeOut, ActivateOut, BusySignalOut,
           RowAddr, ColAddr, SizeOut, LdState, RwState
  );

  modport slave (
    input  CS, RAS, CAS, WeIn, AddrIn, SizeIn, tburst, tburst_config,
           addr_mode, tlat, tpre, tcas, twait,
    output WeOut, ReOut, PrechargeOut, ActivateOut, BusySignalOut,
           RowAddr, ColAddr, SizeOut, LdState, RwState
  );
endinterface

// File: rtl/sdram_enable_unit.sv
// Phase sequencer: FSM, down timer and registered bank strobes.
module sdram_enable_unit
  import sdram_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       startPre,
  input  logic       startAct,
  input  logic       startWr,
  input  logic       startRd,
  input  logic [7:0] tpre,
  input  logic [7:0] tcas,
  input  logic [7:0] tburst,
  input  logic [7:0] twait,
  input  logic [3:0] tlat,
  output ldState_t   LdState,
  output logic       idle,
  output logic       BusySignalOut,
  output logic       WeOut,
  output logic       ReOut,
  output logic       PrechargeOut,
  output logic       ActivateOut,
  output logic       RwState,
  output logic       AddrGenEn
);

  ldState_t   nextState;
  logic [7:0] TimerCount;
  logic [7:0] timerVal;
  logic       TimerLd;
  logic       rwNext;
  logic [7:0] tburstQ, twaitQ;

  assign idle      = (LdState == IDLE);
  assign AddrGenEn = (nextState == BURST);
  assign rwNext    = startWr ? 1'b1 : (startRd ? 1'b0 : RwState);

  // Next-state and timer-load decisions; the timer exits a state at zero.
  always_comb begin
    nextState = LdState;
    TimerLd   = 1'b0;
    timerVal  = 8'd0;
    case (LdState)
      IDLE: begin
        if (startPre) begin
          nextState = PRE;  TimerLd = 1'b1; timerVal = timerLoad(tpre);
        end else if (startAct) begin
          nextState = ACT;  TimerLd = 1'b1; timerVal = timerLoad(tcas);
        end else if (startWr || (startRd && tlat <= 4'd1)) begin
          nextState = BURST; TimerLd = 1'b1; timerVal = timerLoad(tburst);
        end else if (startRd) begin
          // tlat counts from the command edge, so LAT itself lasts tlat-1.
          nextState = LAT;  TimerLd = 1'b1; timerVal = {4'd0, tlat} - 8'd2;
        end
      end
      PRE, ACT, WAIT: begin
        if (TimerCount == 8'd0) nextState = IDLE;
      end
      LAT: begin
        if (TimerCount == 8'd0) begin
          nextState = BURST; TimerLd = 1'b1; timerVal = timerLoad(tburstQ);
        end
      end
      BURST: begin
        if (TimerCount == 8'd0) begin
          nextState = WAIT; TimerLd = 1'b1; timerVal = timerLoad(twaitQ);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State, timer, captured timings and strobes registered from the next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      LdState       <= IDLE;
      TimerCount    <= 8'd0;
      tburstQ       <= 8'd0;
      twaitQ        <= 8'd0;
      RwState       <= 1'b0;
      BusySignalOut <= 1'b0;
      WeOut         <= 1'b0;
      ReOut         <= 1'b0;
      PrechargeOut  <= 1'b0;
      ActivateOut   <= 1'b0;
    end else begin
      LdState <= nextState;
      if (TimerLd)                  TimerCount <= timerVal;
      else if (TimerCount != 8'd0)  TimerCount <= TimerCount - 8'd1;
      if (idle && (startWr || startRd)) begin
        tburstQ <= tburst;
        twaitQ  <= twait;
      end
      RwState       <= rwNext;
      BusySignalOut <= (nextState != IDLE);
      WeOut         <= (nextState == BURST) && rwNext;
      ReOut         <= (nextState == BURST) && !rwNext;
      PrechargeOut  <= idle && (nextState == PRE);
      ActivateOut   <= idle && (nextState == ACT);
    end
  end

endmodule

// File: rtl/sdram_control_unit.sv
// SDRAM control unit: decodes bus commands, tracks the open row, latches
// row/column/size and generates per-beat column addresses.
module sdram_control_unit
  import sdram_ctrl_pkg::*;
(
  input logic Clk,
  input logic Rst,
  sdram_control_unit_if.slave bus
);

  cmd_t       cmd;
  ldState_t   state;
  logic       idle, rowOpen, AddrGenEn;
  logic       startPre, startAct, startWr, startRd;
  logic [7:0] startCol, beat;
  logic [2:0] cfgQ;
  logic       modeQ;
  logic       unusedAddr;

  assign unusedAddr  = ^bus.AddrIn[31:8];
  assign cmd         = decodeCmd(bus.CS, bus.RAS, bus.CAS, bus.WeIn);
  assign startPre    = idle && (cmd == CMD_PRE);
  assign startAct    = idle && (cmd == CMD_ACT);
  assign startWr     = idle && rowOpen && (cmd == CMD_WRITE);
  assign startRd     = idle && rowOpen && (cmd == CMD_READ);
  assign bus.LdState = state;

  sdram_enable_unit u_enable (
    .Clk          (Clk),
    .Rst          (Rst),
    .startPre     (startPre),
    .startAct     (startAct),
    .startWr      (startWr),
    .startRd      (startRd),
    .tpre         (bus.tpre),
    .tcas         (bus.tcas),
    .tburst       (bus.tburst),
    .twait        (bus.twait),
    .tlat         (bus.tlat),
    .LdState      (state),
    .idle         (idle),
    .BusySignalOut(bus.BusySignalOut),
    .WeOut        (bus.WeOut),
    .ReOut        (bus.ReOut),
    .PrechargeOut (bus.PrechargeOut),
    .ActivateOut  (bus.ActivateOut),
    .RwState      (bus.RwState),
    .AddrGenEn    (AddrGenEn)
  );

  // Row-open flag, address/size latches and the burst column counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rowOpen     <= 1'b0;
      bus.RowAddr <= 8'd0;
      bus.ColAddr <= 8'd0;
      bus.SizeOut <= SIZE_BYTE;
      startCol    <= 8'd0;
      beat        <= 8'd0;
      cfgQ        <= 3'd0;
      modeQ       <= 1'b0;
    end else begin
      if (startPre) rowOpen <= 1'b0;
      if (startAct) begin
        rowOpen     <= 1'b1;
        bus.RowAddr <= bus.AddrIn[7:0];
      end
      if (startWr || startRd) begin
        startCol    <= bus.AddrIn[7:0];
        bus.SizeOut <= (bus.SizeIn == SIZE_RSVD) ? SIZE_WORD : bus.SizeIn;
        cfgQ        <= bus.tburst_config;
        modeQ       <= bus.addr_mode;
        // With no latency phase the first beat starts on this same edge.
        if (AddrGenEn) begin
          bus.ColAddr <= bus.AddrIn[7:0];
          beat        <= 8'd1;
        end else begin
          beat        <= 8'd0;
        end
      end else if (AddrGenEn) begin
        bus.ColAddr <= colGen(startCol, beat, cfgQ, modeQ);
        beat        <= beat + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_control_unit.sv
// Directed bench for sdram_control_unit: strobe beats are checked by a
// monitor against a queue of expected records; busy length, latency and
// state are checked by the stimulus process.
module tb_sdram_control_unit;

  localparam int W = 25; // {we,re,pre,act,state[2:0],row[7:0],col[7:0],size[1:0]}

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  sdram_control_unit_if bus();

  sdram_control_unit dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mon_act, mon_exp;

  function automatic logic [W-1:0] pack(input logic we, input logic re,
                                        input logic pre, input logic act,
                                        input logic [2:0] st,
                                        input logic [7:0] row,
                                        input logic [7:0] col,
                                        input logic [1:0] sz);
    return {we, re, pre, act, st, row, col, sz};
  endfunction

  function automatic logic [W-1:0] dut_rec();
    return pack(bus.WeOut, bus.ReOut, bus.PrechargeOut, bus.ActivateOut,
                bus.LdState, bus.RowAddr, bus.ColAddr, bus.SizeOut);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a strobe high must match the next expected record.
  always @(negedge Clk) begin
    if ((bus.WeOut | bus.ReOut | bus.PrechargeOut | bus.ActivateOut) === 1'b1) begin
      mon_act = dut_rec();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got 0x%0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL strobe_beat: got 0x%0h expected 0x%0h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic set_cfg(input logic [7:0] tb, input logic [2:0] cfg,
                         input logic mode, input logic [3:0] lat,
                         input logic [7:0] pre, input logic [7:0] cas,
                         input logic [7:0] wt, input logic [1:0] sz);
    bus.tburst = tb; bus.tburst_config = cfg; bus.addr_mode = mode;
    bus.tlat = lat; bus.tpre = pre; bus.tcas = cas; bus.twait = wt;
    bus.SizeIn = sz;
  endtask

  task automatic nop_lines();
    bus.CS = 1'b1; bus.RAS = 1'b1; bus.CAS = 1'b1; bus.WeIn = 1'b1;
  endtask

  // Issue one command, then scramble the config inputs and count busy cycles.
  task automatic run_cmd(input logic ras, input logic cas, input logic we,
                         input logic [7:0] addr, input bit intrude,
                         output int busy_cnt, output int first_stb,
                         output logic [2:0] first_state);
    bit done;
    @(negedge Clk);
    bus.CS = 1'b0; bus.RAS = ras; bus.CAS = cas; bus.WeIn = we;
    bus.AddrIn = {24'h0, addr};
    @(negedge Clk);
    nop_lines();
    bus.AddrIn = $urandom;
    set_cfg(8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
            8'($urandom_range(1, 255)), 2'($urandom_range(0, 3)));
    busy_cnt = 0; first_stb = -1; first_state = bus.LdState; done = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.BusySignalOut === 1'b1) busy_cnt++;
      if (first_stb < 0 && (bus.WeOut | bus.ReOut | bus.PrechargeOut | bus.ActivateOut) === 1'b1)
        first_stb = c;
      if (bus.BusySignalOut !== 1'b1) begin
        done = 1'b1;
        break;
      end
      if (intrude && c == 2) begin
        bus.CS = 1'b0; bus.RAS = 1'b0; bus.CAS = 1'b1; bus.WeIn = 1'b0;
      end
      if (intrude && c == 3) nop_lines();
      @(negedge Clk);
    end
    nop_lines();
    check("busy_terminates", {31'd0, done}, 32'd1);
  endtask

  int busy_cnt, first_stb;
  logic [2:0] first_state;
  logic [7:0] cols_wr[8] = '{8'hBB, 8'hBC, 8'hBD, 8'hBE, 8'hBF, 8'hB8, 8'hB9, 8'hBA};

  initial begin
    nop_lines();
    bus.AddrIn = 32'h0;
    set_cfg(8'd1, 3'd0, 1'b0, 4'd0, 8'd1, 8'd1, 8'd1, 2'b00);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset_outputs", 32'(dut_rec()), 32'd0);
    check("reset_busy", {31'd0, bus.BusySignalOut}, 32'd0);
    Rst = 1'b0;

    // Write with no open row is ignored.
    set_cfg(8'd4, 3'd2, 1'b1, 4'd2, 8'd2, 8'd2, 8'd2, 2'b10);
    run_cmd(1'b1, 1'b0, 1'b0, 8'h33, 1'b0, busy_cnt, first_stb, first_state);
    check("closed_row_write_busy", busy_cnt, 0);

    // Precharge, tpre=3.
    set_cfg(8'd1, 3'd0, 1'b0, 4'd0, 8'd3, 8'd1, 8'd1, 2'b00);
    exp_q.push_back(pack(0, 0, 1, 0, 3'd1, 8'h00, 8'h00, 2'b00));
    run_cmd(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, busy_cnt, first_stb, first_state);
    check("pre_busy", busy_cnt, 3);
    check("pre_state", 32'(first_state), 1);
    check("pre_idle_after", 32'(bus.LdState), 0);

    // Activate row 0xAA, tcas=5, with a precharge presented mid-busy.
    set_cfg(8'd1, 3'd0, 1'b0, 4'd0, 8'd1, 8'd5, 8'd1, 2'b00);
    exp_q.push_back(pack(0, 0, 0, 1, 3'd2, 8'hAA, 8'h00, 2'b00));
    run_cmd(1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, busy_cnt, first_stb, first_state);
    check("act_busy", busy_cnt, 5);
    check("act_state", 32'(first_state), 2);
    check("act_row", 32'(bus.RowAddr), 32'hAA);

    // Write 0xBB, 8 beats, sequential wrap on 3 bits, twait=3, word size.
    set_cfg(8'd8, 3'd3, 1'b0, 4'd0, 8'd1, 8'd1, 8'd3, 2'b10);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(pack(1, 0, 0, 0, 3'd4, 8'hAA, cols_wr[i], 2'b10));
    run_cmd(1'b1, 1'b0, 1'b0, 8'hBB, 1'b0, busy_cnt, first_stb, first_state);
    check("wr_busy", busy_cnt, 11);
    check("wr_first_beat", first_stb, 1);
    check("wr_state", 32'(first_state), 4);

    // Read 0x5A, tlat=7, 4 linear beats, byte size, twait=2.
    set_cfg(8'd4, 3'd2, 1'b1, 4'd7, 8'd1, 8'd1, 8'd2, 2'b00);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pack(0, 1, 0, 0, 3'd4, 8'hAA, 8'h5A + 8'(i), 2'b00));
    run_cmd(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, busy_cnt, first_stb, first_state);
    check("rd_busy", busy_cnt, 12);
    check("rd_latency", first_stb, 7);
    check("rd_state", 32'(first_state), 3);
    check("rd_size", 32'(bus.SizeOut), 0);
    check("rd_col_hold", 32'(bus.ColAddr), 32'h5D);

    // Read 0x7F, tlat=1 (no LAT), 2 beats wrapping on 1 bit, twait=0, reserved size.
    set_cfg(8'd2, 3'd1, 1'b0, 4'd1, 8'd1, 8'd1, 8'd0, 2'b11);
    exp_q.push_back(pack(0, 1, 0, 0, 3'd4, 8'hAA, 8'h7F, 2'b10));
    exp_q.push_back(pack(0, 1, 0, 0, 3'd4, 8'hAA, 8'h7E, 2'b10));
    run_cmd(1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, busy_cnt, first_stb, first_state);
    check("rd1_busy", busy_cnt, 3);
    check("rd1_first_beat", first_stb, 1);

    // Write 32 beats from 0x10, reset after the fifth beat.
    set_cfg(8'd32, 3'd0, 1'b1, 4'd0, 8'd1, 8'd1, 8'd1, 2'b01);
    for (int i = 0; i < 5; i++)
      exp_q.push_back(pack(1, 0, 0, 0, 3'd4, 8'hAA, 8'h10 + 8'(i), 2'b01));
    @(negedge Clk);
    bus.CS = 1'b0; bus.RAS = 1'b1; bus.CAS = 1'b0; bus.WeIn = 1'b0;
    bus.AddrIn = 32'h10;
    @(negedge Clk);
    nop_lines();
    repeat (4) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_mid_outputs", 32'(dut_rec()), 32'd0);
    check("rst_mid_busy", {31'd0, bus.BusySignalOut}, 32'd0);
    Rst = 1'b0;

    // Row is closed again after reset.
    set_cfg(8'd4, 3'd0, 1'b1, 4'd0, 8'd1, 8'd1, 8'd1, 2'b00);
    run_cmd(1'b1, 1'b0, 1'b1, 8'h44, 1'b0, busy_cnt, first_stb, first_state);
    check("post_rst_read_busy", busy_cnt, 0);

    repeat (3) @(negedge Clk);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_control_unit.md
Name: sdram_control_unit

Overview:
- Command-decoding controller between a bus master and one SDRAM bank model.
- Samples JEDEC-style active-low commands (CS/RAS/CAS/WE) and sequences precharge, activate, and burst read/write phases using programmable timing.
- Drives active-high bank strobes and per-beat row/column addresses.
- Sits between the bus interface and the bank array.

Parameters:
- None. All timing and burst configuration arrive on ports so they can change between transactions.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  reset: synchronous, active-high
- CS, RAS, CAS, WeIn  in  1 each  active-low command lines
- AddrIn  in  32  address; bits [7:0] carry row (activate) or start column (read/write)
- SizeIn  in  2  transfer size: 00 byte, 01 half, 10 word, 11 reserved→treated as word
- tburst  in  8  burst length in beats
- tburst_config  in  3  log2(burst length), wrap-mask width
- addr_mode  in  1  0 sequential-wrap, 1 linear
- tlat  in  4  read CAS latency, counted in cycles from the command edge
- tpre  in  8  precharge busy cycles
- tcas  in  8  activate-to-command busy cycles
- twait  in  8  recovery cycles after a burst
- WeOut, ReOut  out  1  bank write/read strobe, one cycle per beat
- PrechargeOut, ActivateOut  out  1  bank strobes
- BusySignalOut  out  1  high whenever state ≠ IDLE
- RowAddr, ColAddr  out  8  bank address
- SizeOut  out  2  latched SizeIn

Behaviour:
- Command decode, sampled only in IDLE (CS=0):
  - RAS0 CAS1 WE0 = PRECHARGE
  - RAS0 CAS1 WE1 = ACTIVATE
  - RAS1 CAS0 WE0 = WRITE
  - RAS1 CAS0 WE1 = READ
  - Anything else = NOP.
- Commands arriving while busy are ignored (no queuing).
- States (3-bit LdState): IDLE=0, PRE=1, ACT=2, LAT=3, BURST=4, WAIT=5.
- Timer: 8-bit down counter loaded (TimerLd) with N-1 on state entry. State exits when count reaches 0. N=0 behaves as 1.
- PRECHARGE:
  - Enter PRE; PrechargeOut=1 for the first cycle only.
  - Stay tpre cycles, then IDLE.
  - Clears the row-open flag.
- ACTIVATE:
  - Latch RowAddr=AddrIn[7:0] at the command edge.
  - Enter ACT; ActivateOut=1 for the first cycle.
  - Stay tcas cycles, then IDLE.
  - Sets the row-open flag.
- WRITE (only if a row is open, else ignored):
  - At the command edge, latch start column=AddrIn[7:0], SizeOut=SizeIn, RwState=1.
  - Enter BURST next cycle; WeOut=1 for tburst cycles.
  - Then WAIT for twait cycles, then IDLE.
- READ (only if a row is open):
  - Latch as for WRITE with RwState=0.
  - Enter LAT for tlat-1 cycles (skip LAT if tlat≤1).
  - Then BURST with ReOut=1 for tburst cycles, then WAIT for twait cycles, then IDLE.
- Column generation during BURST, beat i = 0..tburst-1 (AddrGenEn=1):
  - Linear (addr_mode=1): ColAddr = start+i mod 256.
  - Sequential (addr_mode=0), k = tburst_config: ColAddr = {start[7:k], (start[k-1:0]+i) mod 2^k}.
  - Outside BURST, ColAddr holds the last value.
- Timing and config inputs are sampled at the command edge; later changes do not affect the transaction in flight.
- Reset (synchronous, Rst=1 at a rising edge):
  - All strobes 0, BusySignalOut 0.
  - RowAddr, ColAddr, SizeOut, TimerCount = 0.
  - State IDLE, row closed.
  - Reset mid-burst aborts immediately.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package sdram_ctrl_pkg:
  - state enum (IDLE..WAIT)
  - command encodings
  - size codes
- Sub-module sdram_enable_unit:
  - FSM, timer, strobes, busy, RwState, AddrGenEn, TimerLd
- Parent sdram_control_unit:
  - command decode, row/column latches, column address generator

Test Plan:
- Reset, then precharge with tpre=3: PrechargeOut high 1 cycle; Busy high 3 cycles; LdState=1 then 0.
- Activate with AddrIn=0xAA, tcas=5: RowAddr=0xAA; ActivateOut 1 cycle; Busy 5 cycles.
- Write with AddrIn=0xBB, tburst=8, tburst_config=3, sequential, twait=3: WeOut high 8 cycles; ColAddr BB,BC,BD,BE,BF,B8,B9,BA; then Busy 3 more cycles.
- Read with AddrIn=0x5A, tlat=7, tburst=4, config=2, linear, SizeIn=00: 6 latency cycles, then ReOut 4 cycles; ColAddr 5A,5B,5C,5D; SizeOut=00.
- Read/write issued with no open row, or any command during Busy: no strobes, state unchanged.
- Rst asserted mid-burst (tburst=32): next edge returns all outputs to 0 and LdState=0.
